// File: rtl/ac_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ac_ctrl_pkg
//  Description : Shared types and constants for the accumulator control unit:
//                FSM state encoding, opcode map, bus-source codes, ALU codes
//                and the packed control-strobe vector.
//  Revision    : 1.0  initial release
// ============================================================================
package ac_ctrl_pkg;

    localparam int IW  = 8;   // opcode width read from the IR
    localparam int BSW = 4;   // bus-source select width

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_INIT = 4'd1,
        S_F1   = 4'd2,
        S_F2   = 4'd3,
        S_DEC  = 4'd4,
        S_EXEC = 4'd5,   // all single-cycle ops, strobes chosen by ir
        S_LD1  = 4'd6,
        S_LD2  = 4'd7,
        S_LD3  = 4'd8,
        S_ST1  = 4'd9,
        S_ST2  = 4'd10,
        S_HALT = 4'd11,
        S_ERR  = 4'd12
    } state_t;

    localparam logic [IW-1:0] OP_NOP   = 8'h00;
    localparam logic [IW-1:0] OP_CLAC  = 8'h01;
    localparam logic [IW-1:0] OP_INAC  = 8'h02;
    localparam logic [IW-1:0] OP_ADD   = 8'h03;
    localparam logic [IW-1:0] OP_SUB   = 8'h04;
    localparam logic [IW-1:0] OP_MVACR = 8'h05;
    localparam logic [IW-1:0] OP_MVRAC = 8'h06;
    localparam logic [IW-1:0] OP_LDAC  = 8'h07;
    localparam logic [IW-1:0] OP_STAC  = 8'h08;
    localparam logic [IW-1:0] OP_JMP   = 8'h09;
    localparam logic [IW-1:0] OP_JMPZ  = 8'h0A;
    localparam logic [IW-1:0] OP_END   = 8'hFF;

    localparam logic [BSW-1:0] BUS_NONE = 4'd0;
    localparam logic [BSW-1:0] BUS_PC   = 4'd1;
    localparam logic [BSW-1:0] BUS_DR   = 4'd2;
    localparam logic [BSW-1:0] BUS_R    = 4'd3;
    localparam logic [BSW-1:0] BUS_AC   = 4'd4;
    localparam logic [BSW-1:0] BUS_MEM  = 4'd5;

    localparam logic [1:0] ALU_ADD  = 2'd0;
    localparam logic [1:0] ALU_SUB  = 2'd1;
    localparam logic [1:0] ALU_PASS = 2'd2;

    typedef struct packed {
        logic [BSW-1:0] bus_sel;
        logic [1:0]     alu_op;
        logic           ac_write;
        logic           ac_inc;
        logic           ac_clr;
        logic           alu_to_ac;
        logic           r_load;
        logic           ar_load;
        logic           dr_load;
        logic           ir_load;
        logic           pc_load;
        logic           pc_inc;
        logic           pc_clr;
        logic           mem_rd;
        logic           mem_wr;
        logic           busy;
        logic           done;
        logic           err;
    } ctrl_t;

    // Opcodes executed entirely in S_EXEC.
    function automatic logic is_single_cycle(input logic [IW-1:0] op);
        case (op)
            OP_NOP, OP_CLAC, OP_INAC, OP_ADD, OP_SUB,
            OP_MVACR, OP_MVRAC, OP_JMP, OP_JMPZ: is_single_cycle = 1'b1;
            default:                             is_single_cycle = 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/ac_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : ac_ctrl_if
//  Description : Bundle between the control unit and the datapath.
//                Inputs to the controller : start, ir, z_flag, mem_ready
//                Outputs from controller  : bus_sel, AC/ALU strobes, register
//                loads, PC control, memory strobes, busy/done/err status.
//                master = controller side, slave = datapath side.
//  Revision    : 1.0  initial release
// ============================================================================
interface ac_ctrl_if;
    import ac_ctrl_pkg::*;

    logic                start;
    logic [IW-1:0]       ir;
    logic                z_flag;
    logic                mem_ready;

    logic [BSW-1:0]      bus_sel;
    logic                ac_write;
    logic                ac_inc;
    logic                ac_clr;
    logic                alu_to_ac;
    logic [1:0]          alu_op;
    logic                r_load;
    logic                ar_load;
    logic                dr_load;
    logic                ir_load;
    logic                pc_load;
    logic                pc_inc;
    logic                pc_clr;
    logic                mem_rd;
    logic                mem_wr;
    logic                busy;
    logic                done;
    logic                err;

    modport master (
        input  start, ir, z_flag, mem_ready,
        output bus_sel, ac_write, ac_inc, ac_clr, alu_to_ac, alu_op,
               r_load, ar_load, dr_load, ir_load, pc_load, pc_inc, pc_clr,
               mem_rd, mem_wr, busy, done, err
    );

    modport slave (
        output start, ir, z_flag, mem_ready,
        input  bus_sel, ac_write, ac_inc, ac_clr, alu_to_ac, alu_op,
               r_load, ar_load, dr_load, ir_load, pc_load, pc_inc, pc_clr,
               mem_rd, mem_wr, busy, done, err
    );
endinterface
`default_nettype wire

// File: rtl/ac_ctrl_unit_decode.sv
`default_nettype none
// ============================================================================
//  Module      : ac_ctrl_decode
//  Description : Combinational strobe table: current state plus ir, z_flag
//                and mem_ready produce the full control vector.
//  Ports       : i_state, i_ir, i_z_flag, i_mem_ready -> o_ctrl
//  Revision    : 1.0  initial release
// ============================================================================
module ac_ctrl_decode
    import ac_ctrl_pkg::*;
(
    input  state_t        i_state,
    input  logic [IW-1:0] i_ir,
    input  logic          i_z_flag,
    input  logic          i_mem_ready,
    output ctrl_t         o_ctrl
);

    always_comb begin
        o_ctrl         = '0;
        o_ctrl.bus_sel = BUS_NONE;
        o_ctrl.alu_op  = ALU_ADD;
        o_ctrl.busy    = !((i_state == S_IDLE) || (i_state == S_HALT) ||
                           (i_state == S_ERR));

        case (i_state)
            S_INIT: begin
                o_ctrl.pc_clr = 1'b1;
                o_ctrl.ac_clr = 1'b1;
            end
            S_F1: begin
                o_ctrl.bus_sel = BUS_PC;
                o_ctrl.ar_load = 1'b1;
            end
            S_F2: begin
                // Read stays asserted through the completing cycle.
                o_ctrl.mem_rd = 1'b1;
                if (i_mem_ready) begin
                    o_ctrl.bus_sel = BUS_MEM;
                    o_ctrl.ir_load = 1'b1;
                    o_ctrl.pc_inc  = 1'b1;
                end
            end
            S_EXEC: begin
                case (i_ir)
                    OP_CLAC:  o_ctrl.ac_clr = 1'b1;
                    OP_INAC:  o_ctrl.ac_inc = 1'b1;
                    OP_ADD: begin
                        o_ctrl.alu_op    = ALU_ADD;
                        o_ctrl.alu_to_ac = 1'b1;
                    end
                    OP_SUB: begin
                        o_ctrl.alu_op    = ALU_SUB;
                        o_ctrl.alu_to_ac = 1'b1;
                    end
                    OP_MVACR: begin
                        o_ctrl.bus_sel = BUS_AC;
                        o_ctrl.r_load  = 1'b1;
                    end
                    OP_MVRAC: begin
                        o_ctrl.bus_sel  = BUS_R;
                        o_ctrl.ac_write = 1'b1;
                    end
                    OP_JMP: begin
                        o_ctrl.bus_sel = BUS_R;
                        o_ctrl.pc_load = 1'b1;
                    end
                    OP_JMPZ: begin
                        if (i_z_flag) begin
                            o_ctrl.bus_sel = BUS_R;
                            o_ctrl.pc_load = 1'b1;
                        end
                    end
                    default: ;  // NOP
                endcase
            end
            S_LD1, S_ST1: begin
                o_ctrl.bus_sel = BUS_R;
                o_ctrl.ar_load = 1'b1;
            end
            S_LD2: begin
                o_ctrl.mem_rd = 1'b1;
                if (i_mem_ready) begin
                    o_ctrl.bus_sel = BUS_MEM;
                    o_ctrl.dr_load = 1'b1;
                end
            end
            S_LD3: begin
                o_ctrl.bus_sel  = BUS_DR;
                o_ctrl.ac_write = 1'b1;
            end
            S_ST2: begin
                o_ctrl.bus_sel = BUS_AC;
                o_ctrl.mem_wr  = 1'b1;
            end
            S_HALT:  o_ctrl.done = 1'b1;
            S_ERR:   o_ctrl.err  = 1'b1;
            default: ;  // IDLE, DEC: no strobes
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/ac_ctrl_unit.sv
`default_nettype none
// ============================================================================
//  Module      : ac_ctrl_unit
//  Description : Microsequencer for the accumulator machine. Runs the
//                fetch/decode/execute loop and drives every datapath strobe.
//  Ports       : clk, rst (sync, active high)
//                bus (ac_ctrl_if.master): start/ir/z_flag/mem_ready in,
//                bus_sel, AC/ALU, register-load, PC, memory and status out.
//  Revision    : 1.0  initial release
// ============================================================================
module ac_ctrl_unit
    import ac_ctrl_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    ac_ctrl_if.master     bus
);

    state_t r_state;
    state_t w_next;
    ctrl_t  w_ctrl;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_HALT, S_ERR: if (bus.start) w_next = S_INIT;
            S_INIT: w_next = S_F1;
            S_F1:   w_next = S_F2;
            S_F2:   if (bus.mem_ready) w_next = S_DEC;
            S_DEC: begin
                case (bus.ir)
                    OP_END:  w_next = S_HALT;
                    OP_LDAC: w_next = S_LD1;
                    OP_STAC: w_next = S_ST1;
                    default: w_next = is_single_cycle(bus.ir) ? S_EXEC : S_ERR;
                endcase
            end
            S_EXEC: w_next = S_F1;
            S_LD1:  w_next = S_LD2;
            S_LD2:  if (bus.mem_ready) w_next = S_LD3;
            S_LD3:  w_next = S_F1;
            S_ST1:  w_next = S_ST2;
            S_ST2:  if (bus.mem_ready) w_next = S_F1;
            default: w_next = S_IDLE;
        endcase
    end

    ac_ctrl_decode u_decode (
        .i_state     (r_state),
        .i_ir        (bus.ir),
        .i_z_flag    (bus.z_flag),
        .i_mem_ready (bus.mem_ready),
        .o_ctrl      (w_ctrl)
    );

    assign bus.bus_sel   = w_ctrl.bus_sel;
    assign bus.ac_write  = w_ctrl.ac_write;
    assign bus.ac_inc    = w_ctrl.ac_inc;
    assign bus.ac_clr    = w_ctrl.ac_clr;
    assign bus.alu_to_ac = w_ctrl.alu_to_ac;
    assign bus.alu_op    = w_ctrl.alu_op;
    assign bus.r_load    = w_ctrl.r_load;
    assign bus.ar_load   = w_ctrl.ar_load;
    assign bus.dr_load   = w_ctrl.dr_load;
    assign bus.ir_load   = w_ctrl.ir_load;
    assign bus.pc_load   = w_ctrl.pc_load;
    assign bus.pc_inc    = w_ctrl.pc_inc;
    assign bus.pc_clr    = w_ctrl.pc_clr;
    assign bus.mem_rd    = w_ctrl.mem_rd;
    assign bus.mem_wr    = w_ctrl.mem_wr;
    assign bus.busy      = w_ctrl.busy;
    assign bus.done      = w_ctrl.done;
    assign bus.err       = w_ctrl.err;

endmodule
`default_nettype wire

// File: tb/tb_ac_ctrl_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ac_ctrl_unit
//  Description : Directed scoreboard bench for ac_ctrl_unit. The stimulus
//                process pushes a hand-written expected output vector for
//                every driven cycle; the monitor pops and compares on the
//                falling edge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ac_ctrl_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ac_ctrl_if dif();

    ac_ctrl_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (dif)
    );

    // Expected vector = {bus_sel[3:0], alu_op[1:0], flags[15:0]}
    localparam logic [15:0] AC_WR  = 16'h0001;
    localparam logic [15:0] AC_INC = 16'h0002;
    localparam logic [15:0] AC_CLR = 16'h0004;
    localparam logic [15:0] ALU_AC = 16'h0008;
    localparam logic [15:0] R_LD   = 16'h0010;
    localparam logic [15:0] AR_LD  = 16'h0020;
    localparam logic [15:0] DR_LD  = 16'h0040;
    localparam logic [15:0] IR_LD  = 16'h0080;
    localparam logic [15:0] PC_LD  = 16'h0100;
    localparam logic [15:0] PC_INC = 16'h0200;
    localparam logic [15:0] PC_CLR = 16'h0400;
    localparam logic [15:0] MEM_RD = 16'h0800;
    localparam logic [15:0] MEM_WR = 16'h1000;
    localparam logic [15:0] BUSY   = 16'h2000;
    localparam logic [15:0] DONE   = 16'h4000;
    localparam logic [15:0] ERR    = 16'h8000;

    function automatic logic [21:0] E(input logic [3:0] b, input logic [1:0] op,
                                      input logic [15:0] f);
        return {b, op, f};
    endfunction

    typedef struct {
        string       name;
        logic [21:0] v;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    logic [7:0] cur_ir = 8'h00;
    logic       cur_z  = 1'b0;

    wire [21:0] w_act = {dif.bus_sel, dif.alu_op,
                         dif.err, dif.done, dif.busy, dif.mem_wr, dif.mem_rd,
                         dif.pc_clr, dif.pc_inc, dif.pc_load, dif.ir_load,
                         dif.dr_load, dif.ar_load, dif.r_load, dif.alu_to_ac,
                         dif.ac_clr, dif.ac_inc, dif.ac_write};

    // Monitor
    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            exp_t e;
            e = sbq.pop_front();
            n_cmp++;
            if (w_act !== e.v) begin
                n_fail++;
                $display("FAIL %s @%0t: got %h expected %h", e.name, $time, w_act, e.v);
            end
        end
    end

    // One clock of stimulus with its expected outputs for that cycle.
    task automatic step(input logic r, input logic s, input logic mr,
                        input string nm, input logic [21:0] ev);
        exp_t e;
        @(posedge clk);
        #1;
        rst           = r;
        dif.start     = s;
        dif.mem_ready = mr;
        dif.ir        = cur_ir;
        dif.z_flag    = cur_z;
        e.name = nm;
        e.v    = ev;
        sbq.push_back(e);
    endtask

    // F1, F2 with 'waits' not-ready cycles, then DEC seeing 'op' in IR.
    task automatic fetch(input logic [7:0] op, input int waits);
        step(0, 0, 1, "F1", E(4'd1, 2'd0, AR_LD | BUSY));
        for (int i = 0; i < waits; i++)
            step(0, 0, 0, "F2wait", E(4'd0, 2'd0, MEM_RD | BUSY));
        step(0, 0, 1, "F2rdy", E(4'd5, 2'd0, MEM_RD | IR_LD | PC_INC | BUSY));
        cur_ir = op;
        step(0, 1, 0, "DEC", E(4'd0, 2'd0, BUSY));  // start ignored while busy
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        dif.start = 1'b0; dif.ir = 8'h00; dif.z_flag = 1'b0; dif.mem_ready = 1'b0;

        // Reset, then start with reset still high: reset wins
        for (int i = 0; i < 3; i++) step(1, 0, 0, "rst", E(4'd0, 2'd0, 16'h0));
        step(1, 1, 1, "rst_start", E(4'd0, 2'd0, 16'h0));
        step(0, 0, 0, "idle", E(4'd0, 2'd0, 16'h0));
        step(0, 0, 0, "idle2", E(4'd0, 2'd0, 16'h0));

        // Program: INAC then END, zero memory wait
        step(0, 1, 0, "idle_start", E(4'd0, 2'd0, 16'h0));
        step(0, 0, 0, "INIT", E(4'd0, 2'd0, PC_CLR | AC_CLR | BUSY));
        fetch(8'h02, 0);
        step(0, 0, 0, "INAC", E(4'd0, 2'd0, AC_INC | BUSY));
        fetch(8'hFF, 0);
        step(0, 0, 0, "HALT", E(4'd0, 2'd0, DONE));
        step(0, 0, 0, "HALT2", E(4'd0, 2'd0, DONE));

        // Restart from HALT: ADD with three wait cycles, then other ops
        step(0, 1, 0, "HALT_start", E(4'd0, 2'd0, DONE));
        step(0, 0, 0, "INIT2", E(4'd0, 2'd0, PC_CLR | AC_CLR | BUSY));
        fetch(8'h03, 3);
        step(0, 0, 0, "ADD", E(4'd0, 2'd0, ALU_AC | BUSY));
        fetch(8'h04, 0);
        step(0, 0, 0, "SUB", E(4'd0, 2'd1, ALU_AC | BUSY));
        fetch(8'h05, 0);
        step(0, 0, 0, "MVACR", E(4'd4, 2'd0, R_LD | BUSY));
        fetch(8'h06, 0);
        step(0, 0, 0, "MVRAC", E(4'd3, 2'd0, AC_WR | BUSY));
        fetch(8'h01, 0);
        step(0, 0, 0, "CLAC", E(4'd0, 2'd0, AC_CLR | BUSY));
        fetch(8'h00, 0);
        step(0, 0, 0, "NOP", E(4'd0, 2'd0, BUSY));
        fetch(8'h09, 0);
        step(0, 0, 0, "JMP", E(4'd3, 2'd0, PC_LD | BUSY));

        // LDAC with two wait cycles in LD2
        fetch(8'h07, 0);
        step(0, 0, 0, "LD1", E(4'd3, 2'd0, AR_LD | BUSY));
        step(0, 0, 0, "LD2wait", E(4'd0, 2'd0, MEM_RD | BUSY));
        step(0, 0, 0, "LD2wait", E(4'd0, 2'd0, MEM_RD | BUSY));
        step(0, 0, 1, "LD2rdy", E(4'd5, 2'd0, MEM_RD | DR_LD | BUSY));
        step(0, 0, 0, "LD3", E(4'd2, 2'd0, AC_WR | BUSY));

        // JMPZ not taken, then taken
        cur_z = 1'b0;
        fetch(8'h0A, 0);
        step(0, 0, 0, "JMPZ_z0", E(4'd0, 2'd0, BUSY));
        cur_z = 1'b1;
        fetch(8'h0A, 0);
        step(0, 0, 0, "JMPZ_z1", E(4'd3, 2'd0, PC_LD | BUSY));

        // STAC with one wait cycle
        fetch(8'h08, 0);
        step(0, 0, 0, "ST1", E(4'd3, 2'd0, AR_LD | BUSY));
        step(0, 0, 0, "ST2wait", E(4'd4, 2'd0, MEM_WR | BUSY));
        step(0, 0, 1, "ST2rdy", E(4'd4, 2'd0, MEM_WR | BUSY));

        // Illegal opcode: sticky error
        fetch(8'h42, 0);
        for (int i = 0; i < 10; i++) begin
            cur_z = i[0];
            step(0, 0, 1, "ERR_sticky", E(4'd0, 2'd0, ERR));
        end
        step(0, 1, 0, "ERR_start", E(4'd0, 2'd0, ERR));
        step(0, 0, 0, "INIT3", E(4'd0, 2'd0, PC_CLR | AC_CLR | BUSY));

        // Reset during ST2 aborts the write
        fetch(8'h08, 0);
        step(0, 0, 0, "ST1b", E(4'd3, 2'd0, AR_LD | BUSY));
        step(1, 0, 0, "ST2_rst", E(4'd4, 2'd0, MEM_WR | BUSY));
        step(0, 0, 0, "after_rst", E(4'd0, 2'd0, 16'h0));
        step(0, 0, 1, "after_rst2", E(4'd0, 2'd0, 16'h0));

        // Drain the scoreboard with a bounded wait
        @(posedge clk);
        for (int i = 0; i < 10 && sbq.size() > 0; i++) @(posedge clk);
        if (sbq.size() > 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", sbq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
